// File: rtl/cordic_dac_pkg.sv
// Shared types and helpers for the CORDIC-to-DAC sample sequencer.
package cordic_dac_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT_TICK,
        ST_START,
        ST_WAIT_CORDIC,
        ST_LOAD,
        ST_WAIT_DAC
    } state_e;

    localparam int DAC_W_DEF = 12;
    localparam int DAC_MID   = 1 << (DAC_W_DEF - 1);

    // Signed value -> w-bit offset-binary code, clamped to [0, 2^w-1].
    function automatic logic [31:0] offset_code(input logic signed [31:0] v, input int w);
        longint mid;
        longint hi;
        longint s;
        if (w >= DAC_W_DEF) begin
            mid = longint'(DAC_MID) << (w - DAC_W_DEF);
        end else begin
            mid = longint'(DAC_MID) >> (DAC_W_DEF - w);
        end
        hi = (longint'(1) << w) - 1;
        s  = longint'(v) + mid;
        if (s < 0) begin
            return '0;
        end else if (s > hi) begin
            return 32'(hi);
        end
        return 32'(s);
    endfunction

endpackage

// File: rtl/cordic_dac_sequencer_if.sv
// Bundle of the sequencer's switch, CORDIC, DAC and status signals.
interface cordic_dac_sequencer_if #(
    parameter int ANGLE_W = 13,
    parameter int RES_W   = 16,
    parameter int DAC_W   = 12
);
    logic                      enable;
    logic signed [ANGLE_W-1:0] step;
    logic                      cordic_start;
    logic signed [ANGLE_W-1:0] cordic_angle;
    logic                      cordic_done;
    logic signed [RES_W-1:0]   cordic_tan;
    logic                      dac_valid;
    logic                      dac_ready;
    logic [DAC_W-1:0]          dac_ch1;
    logic [DAC_W-1:0]          dac_ch2;
    logic                      overrun;
    logic                      timeout;

    modport master (
        input  enable, step, cordic_done, cordic_tan, dac_ready,
        output cordic_start, cordic_angle, dac_valid, dac_ch1, dac_ch2, overrun, timeout
    );

    modport slave (
        output enable, step, cordic_done, cordic_tan, dac_ready,
        input  cordic_start, cordic_angle, dac_valid, dac_ch1, dac_ch2, overrun, timeout
    );
endinterface

// File: rtl/cordic_dac_sample_timer.sv
// Sample-rate divider: counts 0..SAMPLE_DIV-1 while running, tick on the last count.
module cordic_dac_sample_timer #(
    parameter int SAMPLE_DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    input  logic run_i,
    output logic tick_o
);
    localparam int            CW   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SAMPLE_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        if (!run_i || (cnt_q == LAST)) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tick_o = (cnt_q == LAST);

endmodule

// File: rtl/cordic_dac_sequencer.sv
// Per-sample scheduler: sweeps a triangle angle, runs one CORDIC job per tick and
// hands the resulting offset-binary code pair to the DAC serializer.
module cordic_dac_sequencer
    import cordic_dac_pkg::*;
#(
    parameter int ANGLE_W        = 13,
    parameter int RES_W          = 16,
    parameter int DAC_W          = DAC_W_DEF,
    parameter int SAMPLE_DIV     = 5000,
    parameter int ANGLE_LIMIT    = 1024,
    parameter int TAN_SHIFT      = 4,
    parameter int CORDIC_TIMEOUT = 64
) (
    input  logic clk,
    input  logic rst,
    cordic_dac_sequencer_if.master bus
);
    localparam int                      AW1       = ANGLE_W + 1;
    localparam int                      WCW       = $clog2(CORDIC_TIMEOUT + 1);
    localparam logic signed [AW1-1:0]   LIM_P     = AW1'(ANGLE_LIMIT);
    localparam logic signed [AW1-1:0]   LIM_N     = -LIM_P;
    localparam logic signed [AW1-1:0]   SMAX      = AW1'((1 << (ANGLE_W - 1)) - 1);
    localparam logic [WCW-1:0]          WAIT_LAST = WCW'(CORDIC_TIMEOUT - 1);

    state_e                    state_q, state_d;
    logic                      tick;
    logic                      xfer;
    logic                      start;
    logic signed [ANGLE_W-1:0] angle_q, angle_d;
    logic signed [ANGLE_W-1:0] cordic_angle_q, cordic_angle_d;
    logic                      dir_down_q, dir_down_d;
    logic [WCW-1:0]            wait_cnt_q, wait_cnt_d;
    logic [DAC_W-1:0]          tan_code_q, tan_code_d;
    logic [DAC_W-1:0]          dac_ch1_q, dac_ch1_d;
    logic [DAC_W-1:0]          dac_ch2_q, dac_ch2_d;
    logic                      dac_valid_q, dac_valid_d;
    logic                      overrun_q, overrun_d;
    logic                      timeout_q, timeout_d;
    logic signed [AW1-1:0]     step_x, mag, angle_x, sum_up, sum_dn;
    logic signed [31:0]        tan_x, sent_x;

    // Timer is cleared in the same edge that enters IDLE and stays cleared there.
    cordic_dac_sample_timer #(
        .SAMPLE_DIV (SAMPLE_DIV)
    ) u_timer (
        .clk    (clk),
        .rst    (rst),
        .run_i  ((state_q != ST_IDLE) && (state_d != ST_IDLE)),
        .tick_o (tick)
    );

    assign xfer = dac_valid_q && bus.dac_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            angle_q        <= '0;
            cordic_angle_q <= '0;
            dir_down_q     <= 1'b0;
            wait_cnt_q     <= '0;
            tan_code_q     <= '0;
            dac_ch1_q      <= '0;
            dac_ch2_q      <= '0;
            dac_valid_q    <= 1'b0;
            overrun_q      <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            state_q        <= state_d;
            angle_q        <= angle_d;
            cordic_angle_q <= cordic_angle_d;
            dir_down_q     <= dir_down_d;
            wait_cnt_q     <= wait_cnt_d;
            tan_code_q     <= tan_code_d;
            dac_ch1_q      <= dac_ch1_d;
            dac_ch2_q      <= dac_ch2_d;
            dac_valid_q    <= dac_valid_d;
            overrun_q      <= overrun_d;
            timeout_q      <= timeout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:        if (bus.enable) state_d = ST_WAIT_TICK;
            ST_WAIT_TICK: begin
                if (!bus.enable) begin
                    state_d = ST_IDLE;
                end else if (tick) begin
                    state_d = ST_START;
                end
            end
            ST_START:       state_d = ST_WAIT_CORDIC;
            ST_WAIT_CORDIC: begin
                if (bus.cordic_done) begin
                    state_d = ST_LOAD;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d = ST_WAIT_TICK;
                end
            end
            ST_LOAD:        state_d = ST_WAIT_DAC;
            ST_WAIT_DAC:    if (xfer) state_d = bus.enable ? ST_WAIT_TICK : ST_IDLE;
            default:        state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        step_x = {bus.step[ANGLE_W-1], bus.step};
        mag    = step_x[AW1-1] ? -step_x : step_x;
        if (mag > SMAX) begin
            mag = SMAX;
        end
        angle_x = {angle_q[ANGLE_W-1], angle_q};
        sum_up  = angle_x + mag;
        sum_dn  = angle_x - mag;
        // Sign-extend before shifting so the shift stays arithmetic.
        tan_x   = {{(32 - RES_W){bus.cordic_tan[RES_W-1]}}, bus.cordic_tan};
        tan_x   = tan_x >>> TAN_SHIFT;
        sent_x  = {{(32 - ANGLE_W){cordic_angle_q[ANGLE_W-1]}}, cordic_angle_q};

        start          = 1'b0;
        angle_d        = angle_q;
        cordic_angle_d = cordic_angle_q;
        dir_down_d     = dir_down_q;
        wait_cnt_d     = wait_cnt_q;
        tan_code_d     = tan_code_q;
        dac_ch1_d      = dac_ch1_q;
        dac_ch2_d      = dac_ch2_q;
        dac_valid_d    = dac_valid_q;
        timeout_d      = timeout_q;
        overrun_d      = overrun_q | (tick && (state_q != ST_WAIT_TICK));

        case (state_q)
            ST_WAIT_TICK: begin
                if (bus.enable && tick) begin
                    cordic_angle_d = angle_q;
                end
            end
            ST_START: begin
                start      = 1'b1;
                wait_cnt_d = '0;
                if (!dir_down_q) begin
                    if (sum_up >= LIM_P) begin
                        angle_d    = ANGLE_W'(LIM_P);
                        dir_down_d = 1'b1;
                    end else begin
                        angle_d = ANGLE_W'(sum_up);
                    end
                end else begin
                    if (sum_dn <= LIM_N) begin
                        angle_d    = ANGLE_W'(LIM_N);
                        dir_down_d = 1'b0;
                    end else begin
                        angle_d = ANGLE_W'(sum_dn);
                    end
                end
            end
            ST_WAIT_CORDIC: begin
                wait_cnt_d = wait_cnt_q + WCW'(1);
                if (bus.cordic_done) begin
                    tan_code_d = DAC_W'(offset_code(tan_x, DAC_W));
                end else if (wait_cnt_q == WAIT_LAST) begin
                    timeout_d = 1'b1;
                end
            end
            ST_LOAD: begin
                dac_ch1_d   = tan_code_q;
                dac_ch2_d   = DAC_W'(offset_code(sent_x, DAC_W));
                dac_valid_d = 1'b1;
            end
            ST_WAIT_DAC: begin
                if (xfer) begin
                    dac_valid_d = 1'b0;
                end
            end
            default: ;
        endcase
    end

    assign bus.cordic_start = start;
    assign bus.cordic_angle = cordic_angle_q;
    assign bus.dac_valid    = dac_valid_q;
    assign bus.dac_ch1      = dac_ch1_q;
    assign bus.dac_ch2      = dac_ch2_q;
    assign bus.overrun      = overrun_q;
    assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_cordic_dac_sequencer.sv
// Directed bench for cordic_dac_sequencer with a latency-programmable CORDIC responder.
module tb_cordic_dac_sequencer;

    localparam int ANGLE_W = 13;
    localparam int RES_W   = 16;
    localparam int DAC_W   = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    cordic_dac_sequencer_if #(.ANGLE_W(ANGLE_W), .RES_W(RES_W), .DAC_W(DAC_W)) bus ();

    cordic_dac_sequencer #(
        .ANGLE_W        (ANGLE_W),
        .RES_W          (RES_W),
        .DAC_W          (DAC_W),
        .SAMPLE_DIV     (8),
        .ANGLE_LIMIT    (100),
        .TAN_SHIFT      (4),
        .CORDIC_TIMEOUT (64)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_chk  = 0;
    int n_fail = 0;

    int model_lat = 4;
    bit model_on  = 1'b1;
    int model_tan = 0;
    int mcnt      = 0;

    // CORDIC responder: done arrives model_lat cycles after the start cycle.
    initial begin
        bus.cordic_done = 1'b0;
        bus.cordic_tan  = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.cordic_done = 1'b0;
            if (rst) begin
                mcnt = 0;
            end else begin
                if (mcnt > 0) begin
                    mcnt--;
                    if (mcnt == 0) begin
                        bus.cordic_done = 1'b1;
                        bus.cordic_tan  = 16'(model_tan);
                    end
                end
                if (bus.cordic_start && model_on) mcnt = model_lat;
            end
        end
    end

    typedef struct {
        int step;
        int tan;
        int exp_angle;
        int exp_ch1;
        int exp_ch2;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic wait_xfer(output bit ok, output int ang, output int c1, output int c2);
        ok = 1'b0; ang = -9999; c1 = -1; c2 = -1;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            if (bus.cordic_start) ang = int'(bus.cordic_angle);
            if (bus.dac_valid && bus.dac_ready) begin
                ok = 1'b1;
                c1 = int'(bus.dac_ch1);
                c2 = int'(bus.dac_ch2);
            end
        end
    endtask

    task automatic wait_start(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget && !ok; i++) begin
            @(negedge clk);
            if (bus.cordic_start) ok = 1'b1;
        end
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(negedge clk);
            if (bus.dac_valid) ok = 1'b1;
        end
    endtask

    task automatic check_zero(input string pfx);
        check({pfx, "_start"},   bus.cordic_start, 0);
        check({pfx, "_angle"},   int'(bus.cordic_angle), 0);
        check({pfx, "_valid"},   bus.dac_valid, 0);
        check({pfx, "_ch1"},     bus.dac_ch1, 0);
        check({pfx, "_ch2"},     bus.dac_ch2, 0);
        check({pfx, "_overrun"}, bus.overrun, 0);
        check({pfx, "_timeout"}, bus.timeout, 0);
    endtask

    initial begin
        bit ok;
        bit stable;
        bit vseen;
        bit started;
        int ang, c1, c2, d1, d2, nx, ns;

        bus.enable    = 1'b0;
        bus.step      = '0;
        bus.dac_ready = 1'b1;
        rst           = 1'b1;
        repeat (3) @(negedge clk);
        check_zero("reset");
        rst = 1'b0;

        //          step    tan    angle  ch1   ch2
        vecs[0]  = '{40,    160,    0,    2058, 2048};
        vecs[1]  = '{40,    160,    40,   2058, 2088};
        vecs[2]  = '{40,    32767,  80,   4095, 2128};
        vecs[3]  = '{-40,   -32768, 100,  0,    2148};
        vecs[4]  = '{-40,   -16,    60,   2047, 2108};
        vecs[5]  = '{40,    0,      20,   2048, 2068};
        vecs[6]  = '{40,    15,     -20,  2048, 2028};
        vecs[7]  = '{40,    -17,    -60,  2046, 1988};
        vecs[8]  = '{40,    1000,   -100, 2110, 1948};
        vecs[9]  = '{0,     160,    -60,  2058, 1988};
        vecs[10] = '{-4096, 32000,  -60,  4048, 1988};
        vecs[11] = '{1,     160,    100,  2058, 2148};

        bus.enable = 1'b1;
        for (int i = 0; i < 12; i++) begin
            bus.step  = 13'(vecs[i].step);
            model_tan = vecs[i].tan;
            wait_xfer(ok, ang, c1, c2);
            check($sformatf("vec%0d_xfer", i), ok, 1);
            check($sformatf("vec%0d_angle", i), ang, vecs[i].exp_angle);
            check($sformatf("vec%0d_ch1", i), c1, vecs[i].exp_ch1);
            check($sformatf("vec%0d_ch2", i), c2, vecs[i].exp_ch2);
        end
        check("no_overrun_in_steady_run", bus.overrun, 0);

        // Backpressure: hold the pair for 20 clocks, several ticks are dropped.
        bus.step      = 13'(40);
        model_tan     = 160;
        bus.dac_ready = 1'b0;
        wait_valid(ok);
        check("bp_valid_seen", ok, 1);
        d1 = int'(bus.dac_ch1);
        d2 = int'(bus.dac_ch2);
        stable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (!bus.dac_valid || int'(bus.dac_ch1) != d1 || int'(bus.dac_ch2) != d2) stable = 1'b0;
        end
        check("bp_stable", stable, 1);
        check("bp_overrun", bus.overrun, 1);
        model_on      = 1'b0;
        bus.dac_ready = 1'b1;
        nx = 0;
        started = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (bus.dac_valid && bus.dac_ready) nx++;
            @(negedge clk);
            if (bus.cordic_start) started = 1'b1;
        end
        check("bp_one_xfer", nx, 1);

        // Timeout: the responder stays silent for the next job.
        if (!started) wait_start(100, started);
        check("to_job_started", started, 1);
        vseen = 1'b0;
        for (int i = 0; i < 90 && !bus.timeout; i++) begin
            @(negedge clk);
            if (bus.dac_valid) vseen = 1'b1;
        end
        check("to_flag", bus.timeout, 1);
        check("to_no_valid", vseen, 0);
        model_on = 1'b1;
        wait_start(30, ok);
        check("to_fresh_start", ok, 1);
        wait_xfer(ok, ang, c1, c2);
        check("to_recover_xfer", ok, 1);
        check("to_recover_ch1", c1, 2058);

        // Enable drop mid-job: the sample completes, then the block idles.
        wait_start(30, ok);
        check("en_low_job_started", ok, 1);
        bus.enable = 1'b0;
        wait_xfer(ok, ang, c1, c2);
        check("en_low_completes", ok, 1);
        ns = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (bus.cordic_start || bus.dac_valid) ns++;
        end
        check("en_low_idle", ns, 0);

        // Reset while a pair is being offered.
        bus.step      = 13'(40);
        model_tan     = 160;
        bus.dac_ready = 1'b0;
        bus.enable    = 1'b1;
        wait_valid(ok);
        check("rst_valid_seen", ok, 1);
        rst = 1'b1;
        @(negedge clk);
        check_zero("rst_mid");
        rst           = 1'b0;
        bus.dac_ready = 1'b1;
        wait_xfer(ok, ang, c1, c2);
        check("rst_x0_xfer", ok, 1);
        check("rst_x0_angle", ang, 0);
        check("rst_x0_ch1", c1, 2058);
        check("rst_x0_ch2", c2, 2048);
        wait_xfer(ok, ang, c1, c2);
        check("rst_x1_angle", ang, 40);
        check("rst_x1_ch2", c2, 2088);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
